// File: rtl/blink_driver_pkg.sv
// Shared mode codes for the master FSM / blink driver control interface.
package blink_driver_pkg;

  typedef enum logic [2:0] {
    MODE_OFF1   = 3'd0,
    MODE_ILL1   = 3'd1,
    MODE_ON     = 3'd2,
    MODE_OFF2   = 3'd3,
    MODE_FLASH1 = 3'd4,
    MODE_OFF3   = 3'd5,
    MODE_FLASH2 = 3'd6,
    MODE_ILL7   = 3'd7
  } mode_e;

  function automatic logic is_flash(mode_e m);
    return (m == MODE_FLASH1) || (m == MODE_FLASH2);
  endfunction

endpackage

// File: rtl/blink_driver_dffr.sv
// Plain D flip-flop bank with synchronous active-high reset to a fixed value.
module blink_driver_dffr #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register with reset taking priority over the data input.
  always_ff @(posedge clk) begin
    if (reset) q <= RST_VAL;
    else       q <= d;
  end

endmodule

// File: rtl/blink_driver_speed_reg.sv
// Saturating up/down speed setting for one flash channel. 'changed' flags
// that the register will take a new value on the coming edge, so the timer
// can restart in the same cycle the new half-period takes effect.
module blink_driver_speed_reg #(
  parameter int SPEED_W   = 3,
  parameter int MAX_SPEED = 7,
  parameter int SPEED_RST = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [SPEED_W-1:0] speed,
  output logic               changed
);

  logic [SPEED_W-1:0] speed_d;

  // Step by one in the pulsed direction, clamp at both ends; opposing pulses cancel.
  always_comb begin
    speed_d = speed;
    if (inc && !dec && (speed != SPEED_W'(MAX_SPEED)))
      speed_d = speed + 1'b1;
    else if (dec && !inc && (speed != '0))
      speed_d = speed - 1'b1;
  end

  assign changed = (speed_d != speed);

  blink_driver_dffr #(.W(SPEED_W), .RST_VAL(SPEED_W'(SPEED_RST))) u_speed_q (
    .clk   (clk),
    .reset (reset),
    .d     (speed_d),
    .q     (speed)
  );

endmodule

// File: rtl/blink_driver.sv
// LED driver: decodes the master FSM mode code into steady on/off or a
// square-wave flash whose half-period is BASE_HALF << speed of the active channel.
module blink_driver
  import blink_driver_pkg::*;
#(
  parameter int BASE_HALF = 1000000,
  parameter int COUNT_W   = 32,
  parameter int SPEED_W   = 3,
  parameter int MAX_SPEED = 7,
  parameter int SPEED_RST = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         mode,
  input  logic               shift_left1,
  input  logic               shift_right1,
  input  logic               shift_left2,
  input  logic               shift_right2,
  output logic               light,
  output logic [SPEED_W-1:0] speed1,
  output logic [SPEED_W-1:0] speed2
);

  localparam logic [COUNT_W-1:0] BASE = COUNT_W'(BASE_HALF);

  mode_e              mode_cur;
  logic [2:0]         prev_mode;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] cnt_d;
  logic [COUNT_W-1:0] half_m1;
  logic [SPEED_W-1:0] speed_act;
  logic               spd_chg;
  logic               chg1;
  logic               chg2;
  logic               light_d;

  assign mode_cur = mode_e'(mode);

  blink_driver_speed_reg #(.SPEED_W(SPEED_W), .MAX_SPEED(MAX_SPEED), .SPEED_RST(SPEED_RST)) u_speed1 (
    .clk     (clk),
    .reset   (reset),
    .inc     (shift_left1),
    .dec     (shift_right1),
    .speed   (speed1),
    .changed (chg1)
  );

  blink_driver_speed_reg #(.SPEED_W(SPEED_W), .MAX_SPEED(MAX_SPEED), .SPEED_RST(SPEED_RST)) u_speed2 (
    .clk     (clk),
    .reset   (reset),
    .inc     (shift_left2),
    .dec     (shift_right2),
    .speed   (speed2),
    .changed (chg2)
  );

  // Next light/timer value: steady modes clear the timer, flash restarts on
  // entry or active-speed change (entry wins), otherwise counts to H-1 and toggles.
  always_comb begin
    cnt_d     = '0;
    light_d   = 1'b0;
    speed_act = speed1;
    spd_chg   = chg1;
    if (mode_cur == MODE_FLASH2) begin
      speed_act = speed2;
      spd_chg   = chg2;
    end
    half_m1 = (BASE << speed_act) - COUNT_W'(1);

    if (mode_cur == MODE_ON) begin
      light_d = 1'b1;
    end else if (is_flash(mode_cur)) begin
      if (mode != prev_mode) begin
        light_d = 1'b1;
      end else if (spd_chg) begin
        light_d = light;
      end else if (cnt == half_m1) begin
        light_d = ~light;
      end else begin
        light_d = light;
        cnt_d   = cnt + COUNT_W'(1);
      end
    end
  end

  blink_driver_dffr #(.W(COUNT_W)) u_cnt_q (
    .clk (clk), .reset (reset), .d (cnt_d), .q (cnt)
  );

  blink_driver_dffr #(.W(1)) u_light_q (
    .clk (clk), .reset (reset), .d (light_d), .q (light)
  );

  blink_driver_dffr #(.W(3), .RST_VAL(MODE_OFF1)) u_prev_mode_q (
    .clk (clk), .reset (reset), .d (mode), .q (prev_mode)
  );

endmodule
